debug_trace_fifo: RTL
=====================

Name: debug_trace_fifo

Overview:
Commit-trace capture stage directly downstream of the CPU core's debug write-back port (debug_reg_write_en/addr/data, debug_pc_addr). Filters real register writes, buffers them in a first-word-fall-through (FWFT) FIFO, and presents them to a host or bench over a valid/ready stream. Detects the end-of-program marker write and raises a sticky halt.

Parameters:
DEPTH, 16, number of FIFO entries; power of two, minimum 2.
HALT_DATA, 32'habcd0000, register-write value that signals end of program.
CNT_W, 16, width of the saturating drop counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
debug_reg_write_en  input  1  core write-back enable.
debug_reg_write_addr  input  5  core write-back register index.
debug_reg_write_data  input  32  core write-back data.
debug_pc_addr  input  32  PC of the committing instruction.
trace_valid  output  1  head entry available.
trace_ready  input  1  consumer accepts the head entry.
trace_pc  output  32  head entry PC.
trace_reg  output  5  head entry register index.
trace_data  output  32  head entry write data.
overflow  output  1  sticky flag: at least one capture was dropped.
drop_count  output  CNT_W  number of dropped captures, saturating.
halt  output  1  sticky flag: HALT_DATA has been captured.
level  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Reset values: trace_valid=0, trace_pc/trace_reg/trace_data=0, overflow=0, drop_count=0, halt=0, level=0.
  - Read and write pointers are cleared.
  - Reset mid-stream discards all entries immediately, with no wait for clk.
- Capture condition (cap): debug_reg_write_en=1 AND debug_reg_write_addr!=0 AND halt=0. Writes to $0 are never captured.
- Push: on a rising edge with cap=1, the entry {pc, reg, data} is written when the FIFO is not full, or when it is full and a pop happens in the same cycle.
- Pop: on a rising edge with trace_valid=1 and trace_ready=1, the read pointer advances.
- Latency: an entry pushed at edge N is visible at the outputs (trace_valid=1) after edge N. Outputs are registered.
- Empty FIFO:
  - trace_valid=0.
  - trace_ready is ignored.
  - Output data holds its last value.
- Full FIFO:
  - A cap with no simultaneous pop is dropped.
  - The drop sets overflow=1 and increments drop_count, saturating at all-ones.
  - The FIFO contents are unchanged.
- Simultaneous push and pop with level between 1 and DEPTH: level is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by the extra MSB in level.
- Halt:
  - When an accepted push carries data==HALT_DATA, halt goes to 1 on that edge.
  - halt is sticky until reset.
  - The halt entry itself is stored.
  - All later captures are ignored and are not counted as drops.
  - Draining continues normally after halt.
- If the HALT_DATA write is dropped because the FIFO is full, halt still asserts. That drop is counted.

Optional Feature:
TRACE_TIMESTAMP_EN
- Defined:
  - Adds output trace_cycle (32 bits) carrying a free-running cycle counter value stored with each entry.
  - The counter resets to 0 and increments every clk, wrapping at 2^32.
  - The stored value is the counter value on the capture edge.
  - The entry width grows by 32 bits.
- Undefined: neither the port nor the counter exists.

Decomposition:
- The shared header holds ADDR_BUS (31:0), DATA_BUS (31:0), REG_ADDR_BUS (4:0) and the default HALT_DATA constant, reusing the core's bus definitions.
- One natural sub-module, sync_fifo_fwft: a generic width/depth FIFO with push/pop/full/empty/level.
- debug_trace_fifo wraps sync_fifo_fwft with the capture filter, halt logic and drop counter.

Test Plan:
- Single capture: write en=1, addr=5, data=0x12345678, pc=0xBFC00004 with ready=1 -> next cycle trace_valid=1 with those values; pops; level returns to 0.
- $0 filter: en=1, addr=0, data=0xFFFFFFFF -> trace_valid stays 0, level=0.
- Overflow: ready=0, DEPTH+3 captures with data 1..19 -> level=16, overflow=1, drop_count=3; draining yields data 1..16 in order.
- Full plus simultaneous pop: FIFO full, ready=1, capture data=0xAA -> accepted, level stays 16, no drop; 0xAA is the last entry drained.
- Halt: capture 0xabcd0000, then 0x1 -> halt=1 after the first edge; only 0xabcd0000 is queued; drop_count unchanged.
- Reset mid-stream: 5 entries queued, pulse rst_n low between edges -> trace_valid, level, overflow and halt are all 0 immediately.

Source files
------------

// File: rtl/debug_trace_fifo_pkg.sv
// Shared bus definitions for the debug trace capture path (core write-back widths).
// The TRACE_TIMESTAMP_EN macro adds a 32-bit cycle stamp to each trace entry.
package debug_trace_fifo_pkg;

  typedef logic [31:0] addr_bus_t;
  typedef logic [31:0] data_bus_t;
  typedef logic [4:0]  reg_addr_bus_t;

  localparam logic [31:0] HALT_DATA_DEFAULT = 32'habcd0000;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]   cycle;
`endif
    addr_bus_t     pc;
    reg_addr_bus_t reg_idx;
    data_bus_t     data;
  } trace_entry_t;

endpackage

// File: rtl/debug_trace_fifo_fifo.sv
// Generic first-word-fall-through FIFO whose head output is held in a register.
// The head register keeps its last value while the FIFO is empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_valid;
  logic [WIDTH-1:0] r_head;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [LW-1:0]    w_level_nxt;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic             w_bypass;

  assign w_full       = (r_level == LW'(DEPTH));
  assign w_pop        = i_pop & r_valid;
  assign w_push       = i_push & (~w_full | w_pop);
  assign w_level_nxt  = r_level + LW'(w_push) - LW'(w_pop);
  assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
  // The new head is the word being written this cycle when nothing older remains.
  assign w_bypass     = ((r_level - LW'(w_pop)) == {LW{1'b0}});

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
      r_valid  <= 1'b0;
      r_head   <= {WIDTH{1'b0}};
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_valid  <= (w_level_nxt != {LW{1'b0}});
      if (w_level_nxt != {LW{1'b0}}) begin
        r_head <= w_bypass ? i_data : r_mem[w_rd_ptr_nxt];
      end else begin
        r_head <= r_head;
      end
    end
  end

  assign o_data  = r_head;
  assign o_full  = w_full;
  assign o_empty = ~r_valid;
  assign o_level = r_level;

endmodule

// File: rtl/debug_trace_fifo.sv
// Commit-trace capture: filters core register writes into a FWFT FIFO, counts drops, latches halt.
// Define TRACE_TIMESTAMP_EN to stamp each entry with a free-running cycle count (trace_cycle).
module debug_trace_fifo
  import debug_trace_fifo_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] HALT_DATA = HALT_DATA_DEFAULT,
  parameter int          CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   debug_reg_write_en,
  input  logic [4:0]             debug_reg_write_addr,
  input  logic [31:0]            debug_reg_write_data,
  input  logic [31:0]            debug_pc_addr,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [31:0]            trace_pc,
  output logic [4:0]             trace_reg,
  output logic [31:0]            trace_data,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   halt,
`ifdef TRACE_TIMESTAMP_EN
  output logic [31:0]            trace_cycle,
`endif
  output logic [$clog2(DEPTH):0] level
);

  localparam int EW = $bits(trace_entry_t);

  logic             r_halt;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_count;

  logic             w_cap;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  trace_entry_t     w_entry;
  trace_entry_t     w_head;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]      r_cycle;

  // Free-running cycle counter sampled into each captured entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  assign w_entry.cycle = r_cycle;
  assign trace_cycle   = w_head.cycle;
`endif

  assign w_cap = debug_reg_write_en & (debug_reg_write_addr != 5'd0) & ~r_halt;
  // A full FIFO only drops when the consumer is not freeing a slot this same edge.
  assign w_drop = w_cap & w_full & ~(trace_ready & ~w_empty);

  assign w_entry.pc      = debug_pc_addr;
  assign w_entry.reg_idx = debug_reg_write_addr;
  assign w_entry.data    = debug_reg_write_data;

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_cap),
    .i_pop   (trace_ready),
    .i_data  (w_entry),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // Sticky halt, overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halt       <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= {CNT_W{1'b0}};
    end else begin
      if (w_cap && (debug_reg_write_data == HALT_DATA)) begin
        r_halt <= 1'b1;
      end else begin
        r_halt <= r_halt;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
      if (w_drop && (r_drop_count != {CNT_W{1'b1}})) begin
        r_drop_count <= r_drop_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_drop_count <= r_drop_count;
      end
    end
  end

  assign trace_valid = ~w_empty;
  assign trace_pc    = w_head.pc;
  assign trace_reg   = w_head.reg_idx;
  assign trace_data  = w_head.data;
  assign overflow    = r_overflow;
  assign drop_count  = r_drop_count;
  assign halt        = r_halt;

endmodule
